// File: rtl/taxi_pkg.sv
// taxi_pkg: trip states, datapath widths and the double-dabble digit adjust shared by the taxi meter blocks
package taxi_pkg;
    typedef enum logic [1:0] {IDLE, RUN, HOLD} trip_state_e;
    localparam int FARE_W = 14;
    localparam int BCD_W  = 16;
    localparam logic [FARE_W-1:0] DIST_MAX = 14'd9999;
    function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        for (int i = 0; i < BCD_W / 4; i++)
            r[i*4 +: 4] = (v[i*4 +: 4] >= 4'd5) ? v[i*4 +: 4] + 4'd3 : v[i*4 +: 4];
        return r;
    endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, one shift-add-3 per cycle; bcd is final while done is high
module bin2bcd_seq
    import taxi_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [FARE_W-1:0] bin,
    output logic              busy,
    output logic              done,
    output logic [BCD_W-1:0]  bcd
);
    localparam logic [3:0] LAST = 4'(FARE_W);
    logic [FARE_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]  acc_q, acc_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d;
    always_comb begin
        acc_d  = acc_q;
        bin_d  = bin_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done   = busy_q && cnt_q == LAST;
        if (start && !busy_q) begin
            acc_d  = '0;
            bin_d  = bin;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (done) begin
            busy_d = 1'b0;
        end else if (busy_q) begin
            acc_d = BCD_W'({dabble_adj(acc_q), bin_q[FARE_W-1]});
            bin_d = {bin_q[FARE_W-2:0], 1'b0};
            cnt_d = cnt_q + 4'd1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            bin_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            bin_q  <= bin_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end
    assign busy = busy_q;
    assign bcd  = acc_q;
endmodule

// File: rtl/fare_accum.sv
// fare_accum: trip state machine with saturating fare/distance accumulation and a BCD copy of the fare
module fare_accum
    import taxi_pkg::*;
#(
    parameter logic [FARE_W-1:0] BASE_FARE = 14'd100,
    parameter logic [FARE_W-1:0] BASE_DIST = 14'd30,
    parameter logic [FARE_W-1:0] DIST_FARE = 14'd2,
    parameter logic [FARE_W-1:0] WAIT_FARE = 14'd10,
    parameter logic [FARE_W-1:0] FARE_MAX  = 14'd9999
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trip_start,
    input  logic              trip_end,
    input  logic              dist_pulse,
    input  logic              wait_fare_pulse,
    output logic [FARE_W-1:0] fare,
    output logic [FARE_W-1:0] dist_cnt,
    output logic [BCD_W-1:0]  fare_bcd,
    output logic              running,
    output logic              hold
);
    trip_state_e       state_q, state_d;
    logic [FARE_W-1:0] fare_q, fare_d, dist_q, dist_d, dist_add, wait_add;
    logic [FARE_W:0]   sum;
    logic [2:0]        sync_q, sync_d;
    logic              wait_edge_q, wait_edge_d, fare_chg_q, fare_chg_d;
    logic              running_q, hold_q;
    logic [BCD_W-1:0]  fare_bcd_q, fare_bcd_d, bcd_val;
    logic              bcd_start, bcd_busy, bcd_done;
    always_comb begin
        state_d  = state_q;
        fare_d   = fare_q;
        dist_d   = dist_q;
        dist_add = (dist_pulse && dist_q >= BASE_DIST) ? DIST_FARE : '0;
        wait_add = wait_edge_q ? WAIT_FARE : '0;
        sum      = {1'b0, fare_q} + {1'b0, dist_add} + {1'b0, wait_add};
        // trip_end freezes before any same-cycle event is counted
        if (state_q == RUN) begin
            if (trip_end)
                state_d = HOLD;
            else begin
                fare_d = (sum > {1'b0, FARE_MAX}) ? FARE_MAX : sum[FARE_W-1:0];
                dist_d = (dist_pulse && dist_q < DIST_MAX) ? dist_q + 14'd1 : dist_q;
            end
        end else if (trip_start) begin
            state_d = RUN;
            fare_d  = BASE_FARE;
            dist_d  = '0;
        end
        sync_d      = {sync_q[1:0], wait_fare_pulse};
        wait_edge_d = sync_q[1] & ~sync_q[2];
        bcd_start   = fare_chg_q && !bcd_busy;
        // a change landing while the converter runs keeps the flag for a rerun
        fare_chg_d  = (fare_d != fare_q) || (fare_chg_q && !bcd_start);
        fare_bcd_d  = bcd_done ? bcd_val : fare_bcd_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fare_q      <= '0;
            dist_q      <= '0;
            sync_q      <= '0;
            wait_edge_q <= 1'b0;
            fare_chg_q  <= 1'b0;
            fare_bcd_q  <= '0;
            running_q   <= 1'b0;
            hold_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fare_q      <= fare_d;
            dist_q      <= dist_d;
            sync_q      <= sync_d;
            wait_edge_q <= wait_edge_d;
            fare_chg_q  <= fare_chg_d;
            fare_bcd_q  <= fare_bcd_d;
            running_q   <= state_d == RUN;
            hold_q      <= state_d == HOLD;
        end
    end
    bin2bcd_seq u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (bcd_start),
        .bin   (fare_q),
        .busy  (bcd_busy),
        .done  (bcd_done),
        .bcd   (bcd_val)
    );
    assign fare     = fare_q;
    assign dist_cnt = dist_q;
    assign fare_bcd = fare_bcd_q;
    assign running  = running_q;
    assign hold     = hold_q;
endmodule
